// File: rtl/mem_resp_if.sv
// mem_resp_if: load/store bus between the core (master) and the data-memory
// responder (slave).
//
//   req    master->slave  request strobe, sampled only while ready=1
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  byte address, word index = addr[ADDR_W-1:2]
//   wdata  master->slave  store data
//   ready  slave->master  responder idle, request can be accepted
//   valid  slave->master  one-cycle response strobe
//   rdata  slave->master  load data, meaningful while valid=1
//   err    slave->master  misaligned-access flag, qualified by valid
interface mem_resp_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ready, valid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, valid, rdata, err
    );
endinterface

// File: rtl/mem_resp.sv
// mem_resp: data-memory responder for the multicycle RISC-V core.
//
// Accepts one word access at a time, waits LATENCY cycles, then returns a
// one-cycle valid response. The data memory lives inside this block.
//
// Parameters
//   ADDR_W   byte-address width, memory depth is 2^(ADDR_W-2) words
//   DATA_W   data width (only 32 is supported)
//   LATENCY  wait cycles between acceptance and response, 0..15
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous reset, ACTIVE HIGH despite the name (1 = reset)
//   bus    mem_resp_if.slave: req/we/addr/wdata in, ready/valid/rdata/err out
//
// Optional feature
//   MEM_MISALIGN_TRAP_EN  when defined, accesses with addr[1:0]!=0 do not
//                         touch memory, return rdata=0 and raise err with
//                         valid. When undefined, err is tied low and
//                         addr[1:0] is ignored.
//
// Timing: request accepted at edge E0, memory committed at edge E0+LATENCY,
// valid high in the cycle after that edge, ready again one cycle later.
module mem_resp #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_resp_if.slave bus
);
    localparam int         WORD_W = ADDR_W - 2;
    localparam int         DEPTH  = 1 << WORD_W;
    localparam logic [3:0] LAT    = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    // accept: request taken this edge; commit: this edge enters RESP
    logic accept;
    logic commit;

    // request captured at acceptance
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // operands used at the commit edge
    logic              cmt_we;
    logic [ADDR_W-1:0] cmt_addr;
    logic [DATA_W-1:0] cmt_wdata;
    logic [WORD_W-1:0] cmt_word;
    logic              cmt_mis;

    logic              ready_q;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    // Memory powers up zeroed in simulation; reset never clears it.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (LAT == 4'd0) begin
                        // zero latency commits on the acceptance edge itself
                        commit    = 1'b1;
                        state_nxt = S_RESP;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = LAT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // In IDLE the only possible commit is the zero-latency one, which must
    // use the live request because nothing has been latched yet.
    assign cmt_we    = (state == S_IDLE) ? bus.we    : lat_we;
    assign cmt_addr  = (state == S_IDLE) ? bus.addr  : lat_addr;
    assign cmt_wdata = (state == S_IDLE) ? bus.wdata : lat_wdata;
    assign cmt_word  = cmt_addr[ADDR_W-1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign cmt_mis = (cmt_addr[1:0] != 2'b00);
`else
    // byte offset has no effect in this build
    logic unused_byte_ofs;
    assign unused_byte_ofs = ^cmt_addr[1:0];
    assign cmt_mis         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State, control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            // outputs decoded from the next state so they are flops
            ready_q <= (state_nxt == S_IDLE);
            valid_q <= (state_nxt == S_RESP);
            err_q   <= commit & cmt_mis;
            if (accept) begin
                lat_we    <= bus.we;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
            end
            // rdata only moves on a commit, so it holds between responses
            if (commit) begin
                rdata_q <= (cmt_we || cmt_mis) ? '0 : mem[cmt_word];
            end
        end
    end

    // Store port. The reset term keeps a zero-latency request presented
    // during reset from writing; otherwise reset holds the FSM in IDLE and
    // a pending store never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (commit && cmt_we && !cmt_mis && !rst_n) begin
            mem[cmt_word] <= cmt_wdata;
        end
    end

    assign bus.ready = ready_q;
    assign bus.valid = valid_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: three responders (LATENCY 2, 0, 3) share clock and reset.
// A transaction-level model predicts ready/valid/rdata/err from the
// acceptance edge and latency; a compare loop checks every cycle, and
// directed sequences pin a few literal values.
module tb_mem_resp;
    localparam int NI = 3;
    localparam logic [NI-1:0][3:0] LAT_OF = {4'd3, 4'd0, 4'd2};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_d   [NI];
    logic        we_d    [NI];
    logic [9:0]  addr_d  [NI];
    logic [31:0] wdata_d [NI];
    logic        ready_o [NI];
    logic        valid_o [NI];
    logic        err_o   [NI];
    logic [31:0] rdata_o [NI];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_resp_if #(.ADDR_W(10), .DATA_W(32)) bus ();
        assign bus.req    = req_d[g];
        assign bus.we     = we_d[g];
        assign bus.addr   = addr_d[g];
        assign bus.wdata  = wdata_d[g];
        assign ready_o[g] = bus.ready;
        assign valid_o[g] = bus.valid;
        assign rdata_o[g] = bus.rdata;
        assign err_o[g]   = bus.err;
        mem_resp #(.ADDR_W(10), .DATA_W(32), .LATENCY(int'(LAT_OF[g]))) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    bit [31:0] mmem      [NI][256];
    bit        pend      [NI];
    bit        resp      [NI];
    int        commit_at [NI];
    bit        p_we      [NI];
    bit        p_mis     [NI];
    int        p_word    [NI];
    bit [31:0] p_wd      [NI];
    bit        e_ready   [NI];
    bit        e_valid   [NI];
    bit        e_err     [NI];
    bit [31:0] e_rdata   [NI];
    int        edges = 0;

    task automatic model_commit(input int i);
        resp[i] = 1'b1;
        pend[i] = 1'b0;
        e_err[i] = p_mis[i];
        if (p_mis[i])   e_rdata[i] = 32'h0;
        else if (p_we[i]) begin
            mmem[i][p_word[i]] = p_wd[i];
            e_rdata[i] = 32'h0;
        end else        e_rdata[i] = mmem[i][p_word[i]];
    endtask

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                pend[i] = 1'b0; resp[i] = 1'b0;
                e_ready[i] = 1'b1; e_valid[i] = 1'b0;
                e_rdata[i] = 32'h0; e_err[i] = 1'b0;
            end
        end else begin
            edges = edges + 1;
            for (int i = 0; i < NI; i++) begin
                if (resp[i]) resp[i] = 1'b0;
                else if (pend[i]) begin
                    if (edges == commit_at[i]) model_commit(i);
                end else if (req_d[i] === 1'b1) begin
                    p_we[i]   = we_d[i];
                    p_word[i] = int'(addr_d[i][9:2]);
                    p_wd[i]   = wdata_d[i];
`ifdef MEM_MISALIGN_TRAP_EN
                    p_mis[i]  = (addr_d[i][1:0] != 2'b00);
`else
                    p_mis[i]  = 1'b0;
`endif
                    if (LAT_OF[i] == 4'd0) model_commit(i);
                    else begin
                        pend[i] = 1'b1;
                        commit_at[i] = edges + int'(LAT_OF[i]);
                    end
                end
                e_valid[i] = resp[i];
                e_ready[i] = !pend[i] && !resp[i];
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("ready[%0d]", i), 32'(ready_o[i]), 32'(e_ready[i]));
                    chk($sformatf("valid[%0d]", i), 32'(valid_o[i]), 32'(e_valid[i]));
                    chk($sformatf("rdata[%0d]", i), rdata_o[i], e_rdata[i]);
                    if (e_valid[i])
                        chk($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(e_err[i]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Present a request for one cycle once ready; acc = cycle it was presented.
    task automatic issue(input int i, input bit w, input logic [9:0] a,
                         input logic [31:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (ready_o[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk($sformatf("issue timeout[%0d]", i), 32'(ready_o[i]), 32'd1);
        req_d[i] = 1'b1; we_d[i] = w; addr_d[i] = a; wdata_d[i] = d;
        acc = cyc;
        @(negedge clk);
        req_d[i] = 1'b0;
    endtask

    task automatic wait_resp(input int i, output logic [31:0] rd, output logic e, output int vc);
        int n;
        n = 0;
        while (valid_o[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk($sformatf("resp timeout[%0d]", i), 32'(valid_o[i]), 32'd1);
        rd = rdata_o[i];
        e  = err_o[i];
        vc = cyc;
    endtask

    initial begin
        int a, v;
        logic [31:0] rd;
        logic e;
        for (int i = 0; i < NI; i++) begin
            req_d[i] = 1'b0; we_d[i] = 1'b0; addr_d[i] = '0; wdata_d[i] = '0;
        end

        // reset held 3 cycles, then released
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset ready", 32'(ready_o[i]), 32'd1);
            chk("reset valid", 32'(valid_o[i]), 32'd0);
            chk("reset rdata", rdata_o[i], 32'd0);
            chk("reset err", 32'(err_o[i]), 32'd0);
        end

        // LATENCY=2: store then load, 3 cycles request-to-valid
        issue(0, 1'b1, 10'h010, 32'hDEADBEEF, a);
        wait_resp(0, rd, e, v);
        chk("L2 store latency", 32'(v - a), 32'd3);
        chk("L2 store rdata", rd, 32'h0);
        issue(0, 1'b0, 10'h010, 32'h0, a);
        wait_resp(0, rd, e, v);
        chk("L2 load latency", 32'(v - a), 32'd3);
        chk("L2 load rdata", rd, 32'hDEADBEEF);

        // LATENCY=0: back-to-back loads with req held high
        issue(1, 1'b1, 10'h000, 32'h11, a);
        wait_resp(1, rd, e, v);
        issue(1, 1'b1, 10'h004, 32'h22, a);
        wait_resp(1, rd, e, v);
        @(negedge clk);
        chk("L0 ready", 32'(ready_o[1]), 32'd1);
        req_d[1] = 1'b1; we_d[1] = 1'b0; addr_d[1] = 10'h000;
        a = cyc;
        @(negedge clk);
        chk("L0 first valid", 32'(valid_o[1]), 32'd1);
        chk("L0 first rdata", rdata_o[1], 32'h11);
        addr_d[1] = 10'h004;
        @(negedge clk);
        chk("L0 second ready", 32'(ready_o[1]), 32'd1);
        chk("L0 accept spacing", 32'(cyc - a), 32'd2);
        @(negedge clk);
        chk("L0 second valid", 32'(valid_o[1]), 32'd1);
        chk("L0 second rdata", rdata_o[1], 32'h22);
        req_d[1] = 1'b0;

        // LATENCY=3: a store pulsed during WAIT is dropped
        issue(2, 1'b0, 10'h040, 32'h0, a);
        chk("L3 busy", 32'(ready_o[2]), 32'd0);
        req_d[2] = 1'b1; we_d[2] = 1'b1; addr_d[2] = 10'h020; wdata_d[2] = 32'h55;
        @(negedge clk);
        req_d[2] = 1'b0;
        wait_resp(2, rd, e, v);
        issue(2, 1'b0, 10'h020, 32'h0, a);
        wait_resp(2, rd, e, v);
        chk("L3 dropped store", rd, 32'h0);

        // reset one cycle after a store is accepted discards it
        issue(0, 1'b1, 10'h030, 32'h0000CAFE, a);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midreset ready", 32'(ready_o[0]), 32'd1);
        chk("midreset valid", 32'(valid_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        issue(0, 1'b0, 10'h030, 32'h0, a);
        wait_resp(0, rd, e, v);
        chk("midreset discarded", rd, 32'h0);

        // misaligned store to 0x013
        issue(0, 1'b1, 10'h013, 32'h77, a);
        wait_resp(0, rd, e, v);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misalign err", 32'(e), 32'd1);
        issue(0, 1'b0, 10'h010, 32'h0, a);
        wait_resp(0, rd, e, v);
        chk("misalign mem unchanged", rd, 32'hDEADBEEF);
`else
        chk("misalign err", 32'(e), 32'd0);
        issue(0, 1'b0, 10'h010, 32'h0, a);
        wait_resp(0, rd, e, v);
        chk("misalign mem written", rd, 32'h77);
`endif

        // random traffic, including requests while busy
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                req_d[i]   = ($urandom_range(0, 2) == 0);
                we_d[i]    = 1'($urandom_range(0, 1));
                addr_d[i]  = 10'($urandom_range(0, 63));
                wdata_d[i] = $urandom;
            end
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) req_d[i] = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
# mem_resp

Data-memory responder for the multicycle RISC-V core: the memory-side end of the load/store interface that the control unit and datapath drive during the execute step. It accepts one word-sized request at a time over a `req`/`ready` handshake, models a programmable access latency, and then returns a single-cycle `valid` response carrying read data. It holds the data memory array itself, so the core's `lw`/`sw` path has a realistic multi-cycle slave behind it.

## Interface
- `ADDR_W`, 10: byte-address width; memory depth is 2^(ADDR_W-2) 32-bit words.
- `DATA_W`, 32: data width. Only 32 is supported.
- `LATENCY`, 2: wait cycles between request acceptance and response; legal range 0..15.

- `clk`  in  1  clock; rising edge active.
- `rst_n`  in  1  reset; asynchronous, active-high (`rst_n`=1 resets the block).
- `req`  in  1  request strobe; sampled only when `ready`=1.
- `we`  in  1  1 = store (write), 0 = load (read).
- `addr`  in  ADDR_W  byte address; word index = `addr[ADDR_W-1:2]`.
- `wdata`  in  DATA_W  store data.
- `ready`  out  1  responder idle; a request can be accepted.
- `valid`  out  1  one-cycle response strobe.
- `rdata`  out  DATA_W  load data; valid while `valid`=1.
- `err`  out  1  misaligned-access flag (see Configuration); qualified by `valid`.

## Operation
- FSM states: IDLE, WAIT, RESP. Down-counter `cnt`, 4 bits.
- IDLE: `ready`=1. If `req`=1 at a rising edge, the block latches `addr`, `we` and `wdata`. With `LATENCY`=0 it goes to RESP. Otherwise it goes to WAIT with `cnt`=`LATENCY`.
- WAIT: `ready`=0. `cnt` decrements every edge. At the edge where `cnt`==1 it goes to RESP.
- Commit edge (the edge entering RESP):
  - Store: `mem[word]` is set to the latched `wdata`.
  - Load: `rdata` is registered from `mem[word]`.
- RESP: `valid`=1 and `ready`=0 for exactly one cycle, then the FSM returns to IDLE.
- `rdata` returns 0 on a store response. It holds its last value outside `valid`.
- Inputs are ignored while `ready`=0. There is no queueing; a request seen while busy is dropped.
- Read-after-write: a load issued after a store's response returns the new data.
- Without the macro, `addr[1:0]` is ignored.
- Memory contents start at all zeros in simulation via initialization. Reset does not clear memory.
- Reset values: state=IDLE, `cnt`=0, `ready`=1, `valid`=0, `rdata`=0, `err`=0.
- Reset mid-operation (WAIT or RESP): the FSM returns to IDLE immediately. A store whose commit edge has not occurred is discarded. `valid` drops asynchronously.

## Timing
- Request accepted at edge E0. `valid` is high in the cycle following edge E0+`LATENCY`.
- Load latency is `LATENCY`+1 cycles from acceptance to `valid`.
- The earliest next acceptance is edge E0+`LATENCY`+2. Throughput is one access per `LATENCY`+2 cycles.
- `ready` and `valid` are registered (Moore) outputs. They are never high together.
- `LATENCY` values above 15 are illegal and are not checked.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A request with `addr[1:0]`≠0 is accepted and follows the same latency.
  - No memory write occurs, `rdata`=0, and `err`=1 during its `valid` cycle.
  - Aligned accesses are unaffected, and `err`=0 for them.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `err` is tied to 0.
  - `addr[1:0]` is ignored, so every access goes to `mem[addr[ADDR_W-1:2]]`.

## Test plan
- Reset: hold `rst_n`=1 for 3 cycles, then release → `ready`=1, `valid`=0, `rdata`=0, `err`=0.
- With `LATENCY`=2: store 0xDEADBEEF at 0x010, then load 0x010 → each `valid` appears 3 cycles after acceptance, and the load returns `rdata`=0xDEADBEEF.
- With `LATENCY`=0: back-to-back loads of 0x000 and 0x004 (after storing 0x11, 0x22), with `req` held high → accepted every 2 cycles, `rdata`=0x11 then 0x22.
- Busy drop: with `LATENCY`=3, pulse `req` (store 0x55 at 0x020) during WAIT → ignored, and a later load of 0x020 returns its prior value.
- Reset mid-WAIT: store 0xCAFE to 0x030, assert `rst_n` one cycle after acceptance → `ready`=1, no `valid`, and a later load of 0x030 returns 0.
- Misaligned: store 0x77 to 0x013:
  - With `MEM_MISALIGN_TRAP_EN` → `valid`=1 with `err`=1, and `mem[4]` is unchanged.
  - Without the macro → `err`=0, and a load of 0x010 returns 0x77.
